// File: rtl/ahb_burst_write_master.sv
// AHB-Lite burst write master.
// Accepts one command (start address, HBURST code, INCR length) and streams write
// beats from a valid/ready source onto the bus as SINGLE / INCR / INCR4 / INCR8 /
// INCR16 transfers, with address/data phase pipelining, HREADY stalls, BUSY on data
// underrun, re-NONSEQ at 1KB boundaries for INCR, and two-cycle ERROR abort.
//
// Ports
//   HCLK, HRESET                        clock, synchronous active-high reset
//   cmd_valid/cmd_ready                 command handshake
//   cmd_addr, cmd_burst, cmd_len        start address, HBURST code, INCR beat count
//   wdata_valid/wdata_ready, wdata      write-data stream
//   HADDR, HTRANS, HWRITE, HSIZE,
//   HBURST, HWDATA                      AHB-Lite master outputs
//   HREADY, HRESP                       AHB-Lite slave response
//   done, err                           end-of-command pulse, err=1 when aborted
module ahb_burst_write_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_burst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              done,
  output logic              err
);

  // Counter must hold both INCR16 (16) and the largest INCR length.
  localparam int unsigned       CNT_W     = (LEN_W > 5) ? LEN_W : 5;
  localparam logic [2:0]        HSIZE_C   = 3'($clog2(DATA_W / 8));
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransBusy   = 2'b01;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  localparam logic [2:0] BurstSingle = 3'b000;
  localparam logic [2:0] BurstIncr   = 3'b001;
  localparam logic [2:0] BurstIncr4  = 3'b011;
  localparam logic [2:0] BurstIncr8  = 3'b101;
  localparam logic [2:0] BurstIncr16 = 3'b111;

  typedef enum logic [1:0] {StIdle, StActive, StLast, StAbort} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   haddr_q, haddr_d;
  logic [2:0]          hburst_q, hburst_d;
  logic [2:0]          hsize_q, hsize_d;
  logic [DATA_W-1:0]   hwdata_q, hwdata_d;
  logic [CNT_W-1:0]    beats_q, beats_d;
  logic                first_q, first_d;   // next beat opens the burst
  logic                dphase_q, dphase_d; // a data phase is outstanding in StActive

  logic [CNT_W-1:0]    beats_init;
  logic [1:0]          htrans;
  logic                first_beat;
  logic                err_now;
  logic                accept;
  logic                done_c;
  logic                err_c;

  always_comb begin
    case (cmd_burst)
      BurstSingle: beats_init = CNT_W'(1);
      BurstIncr:   beats_init = (cmd_len == '0) ? CNT_W'(1) : CNT_W'(cmd_len);
      BurstIncr4:  beats_init = CNT_W'(4);
      BurstIncr8:  beats_init = CNT_W'(8);
      BurstIncr16: beats_init = CNT_W'(16);
      default:     beats_init = CNT_W'(1);
    endcase
  end

  // An INCR beat landing on a 1KB boundary restarts the burst with NONSEQ, and like
  // the opening beat it idles (never BUSY) while no data is available.
  assign first_beat = first_q || (hburst_q == BurstIncr && haddr_q[9:0] == 10'd0);

  // First ERROR cycle of a data phase: drop HTRANS to IDLE immediately.
  assign err_now = HRESP && !HREADY &&
                   ((state_q == StActive && dphase_q) || state_q == StLast);

  always_comb begin
    state_d  = state_q;
    htrans   = TransIdle;
    done_c   = 1'b0;
    err_c    = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid) state_d = StActive;
      end
      StActive: begin
        if (err_now) begin
          state_d = StAbort;
        end else begin
          if (first_beat) htrans = wdata_valid ? TransNonseq : TransIdle;
          else            htrans = wdata_valid ? TransSeq : TransBusy;
          if (HREADY && wdata_valid && beats_q == CNT_W'(1)) state_d = StLast;
        end
      end
      StLast: begin
        if (err_now) begin
          state_d = StAbort;
        end else if (HREADY) begin
          done_c  = 1'b1;
          state_d = StIdle;
        end
      end
      StAbort: begin
        if (HREADY) begin
          done_c  = 1'b1;
          err_c   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // HTRANS is NONSEQ/SEQ only when wdata_valid is high, so ready implies a handshake.
  assign wdata_ready = HREADY && htrans[1];
  assign accept      = wdata_ready && wdata_valid;

  always_comb begin
    haddr_d  = haddr_q;
    hburst_d = hburst_q;
    hsize_d  = hsize_q;
    hwdata_d = hwdata_q;
    beats_d  = beats_q;
    first_d  = first_q;
    dphase_d = dphase_q;
    if (state_q == StIdle && cmd_valid) begin
      haddr_d  = cmd_addr;
      hburst_d = cmd_burst;
      hsize_d  = HSIZE_C;
      beats_d  = beats_init;
      first_d  = 1'b1;
      dphase_d = 1'b0;
    end
    if (accept) begin
      hwdata_d = wdata;
      haddr_d  = haddr_q + ADDR_STEP;
      beats_d  = beats_q - CNT_W'(1);
      first_d  = 1'b0;
      dphase_d = 1'b1;
    end else if (HREADY) begin
      dphase_d = 1'b0;
    end
    if (done_c) begin
      hburst_d = '0;
      hsize_d  = '0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= StIdle;
      haddr_q  <= '0;
      hburst_q <= '0;
      hsize_q  <= '0;
      hwdata_q <= '0;
      beats_q  <= '0;
      first_q  <= 1'b0;
      dphase_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hburst_q <= hburst_d;
      hsize_q  <= hsize_d;
      hwdata_q <= hwdata_d;
      beats_q  <= beats_d;
      first_q  <= first_d;
      dphase_q <= dphase_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign HTRANS    = htrans;
  assign HWRITE    = (htrans != TransIdle);
  assign HADDR     = haddr_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = hburst_q;
  assign HWDATA    = hwdata_q;
  assign done      = done_c;
  assign err       = err_c;

endmodule

// File: tb/tb_ahb_burst_write_master.sv
// Directed bench for ahb_burst_write_master (ADDR_W=32, DATA_W=32, LEN_W=8).
// Inputs change 1 time unit after each rising edge; outputs are checked 2 units later.
module tb_ahb_burst_write_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_burst;
  logic [7:0]  cmd_len;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic        done;
  logic        err;

  int compared   = 0;
  int mismatched = 0;
  int hs_cnt     = 0;
  int hs_base    = 0;

  ahb_burst_write_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .LEN_W (8)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_burst  (cmd_burst),
    .cmd_len    (cmd_len),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata      (wdata),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .done       (done),
    .err        (err)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) if (wdata_valid && wdata_ready) hs_cnt <= hs_cnt + 1;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [1:0] tr, input logic [31:0] addr);
    check({tag, " HTRANS"}, 64'(HTRANS), 64'(tr));
    check({tag, " HADDR"}, 64'(HADDR), 64'(addr));
  endtask

  initial begin
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_burst = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0; HREADY = 1'b1; HRESP = 1'b0;
    step(); step(); settle();
    // Reset state
    check("rst HTRANS", 64'(HTRANS), 64'd0);
    check("rst cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst wdata_ready", 64'(wdata_ready), 64'd0);
    check("rst HWRITE", 64'(HWRITE), 64'd0);
    check("rst HSIZE", 64'(HSIZE), 64'd0);
    check("rst HBURST", 64'(HBURST), 64'd0);
    check("rst HADDR", 64'(HADDR), 64'd0);
    check("rst HWDATA", 64'(HWDATA), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst err", 64'(err), 64'd0);

    // T1 SINGLE at 0x100
    step(); HRESET = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 32'h100; cmd_burst = 3'b000;
    wdata_valid = 1'b1; wdata = 32'hA5A5_A5A5; settle();
    check("t1 cmd_ready", 64'(cmd_ready), 64'd1);
    step(); cmd_valid = 1'b0; settle();
    chk_bus("t1 c1", 2'b10, 32'h100);
    check("t1 HWRITE", 64'(HWRITE), 64'd1);
    check("t1 HSIZE", 64'(HSIZE), 64'd2);
    check("t1 HBURST", 64'(HBURST), 64'd0);
    check("t1 wdata_ready", 64'(wdata_ready), 64'd1);
    check("t1 cmd_ready busy", 64'(cmd_ready), 64'd0);
    step(); wdata_valid = 1'b0; settle();
    check("t1 HWDATA", 64'(HWDATA), 64'hA5A5_A5A5);
    check("t1 HTRANS c2", 64'(HTRANS), 64'd0);
    check("t1 done", 64'(done), 64'd1);
    check("t1 err", 64'(err), 64'd0);
    step(); settle();
    check("t1 done off", 64'(done), 64'd0);
    check("t1 cmd_ready back", 64'(cmd_ready), 64'd1);

    // T2 INCR4 at 0x200, stall on second data phase
    cmd_valid = 1'b1; cmd_addr = 32'h200; cmd_burst = 3'b011;
    wdata_valid = 1'b1; wdata = 32'h1111_0000;
    step(); cmd_valid = 1'b0; settle();
    chk_bus("t2 c1", 2'b10, 32'h200);
    check("t2 HBURST", 64'(HBURST), 64'd3);
    step(); wdata = 32'h1111_0001; settle();
    chk_bus("t2 c2", 2'b11, 32'h204);
    check("t2 HWDATA c2", 64'(HWDATA), 64'h1111_0000);
    step(); wdata = 32'h1111_0002; HREADY = 1'b0; settle();
    chk_bus("t2 c3", 2'b11, 32'h208);
    check("t2 HWDATA c3", 64'(HWDATA), 64'h1111_0001);
    check("t2 stall wdata_ready", 64'(wdata_ready), 64'd0);
    check("t2 stall done", 64'(done), 64'd0);
    step(); HREADY = 1'b1; settle();
    chk_bus("t2 c4 held", 2'b11, 32'h208);
    check("t2 HWDATA held", 64'(HWDATA), 64'h1111_0001);
    step(); wdata = 32'h1111_0003; settle();
    chk_bus("t2 c5", 2'b11, 32'h20C);
    check("t2 HWDATA c5", 64'(HWDATA), 64'h1111_0002);
    check("t2 done early", 64'(done), 64'd0);
    step(); wdata_valid = 1'b0; settle();
    check("t2 HTRANS last", 64'(HTRANS), 64'd0);
    check("t2 HWDATA last", 64'(HWDATA), 64'h1111_0003);
    check("t2 done", 64'(done), 64'd1);
    step(); settle();
    check("t2 single pulse", 64'(done), 64'd0);
    check("t2 HBURST idle", 64'(HBURST), 64'd0);

    // T3 INCR len=3 at 0x300 with a 2-cycle underrun after beat 1
    cmd_valid = 1'b1; cmd_addr = 32'h300; cmd_burst = 3'b001; cmd_len = 8'd3;
    wdata_valid = 1'b1; wdata = 32'hE000_0000;
    step(); cmd_valid = 1'b0; settle();
    chk_bus("t3 c1", 2'b10, 32'h300);
    step(); wdata_valid = 1'b0; settle();
    chk_bus("t3 c2 busy", 2'b01, 32'h304);
    check("t3 busy wdata_ready", 64'(wdata_ready), 64'd0);
    check("t3 HWRITE busy", 64'(HWRITE), 64'd1);
    step(); settle();
    chk_bus("t3 c3 busy", 2'b01, 32'h304);
    step(); wdata_valid = 1'b1; wdata = 32'hE000_0001; settle();
    chk_bus("t3 c4", 2'b11, 32'h304);
    step(); wdata = 32'hE000_0002; settle();
    chk_bus("t3 c5", 2'b11, 32'h308);
    check("t3 HWDATA c5", 64'(HWDATA), 64'hE000_0001);
    step(); wdata_valid = 1'b0; settle();
    check("t3 HTRANS last", 64'(HTRANS), 64'd0);
    check("t3 HWDATA last", 64'(HWDATA), 64'hE000_0002);
    check("t3 done", 64'(done), 64'd1);
    step(); settle();

    // T4 INCR len=4 at 0x3F8 crossing 1KB
    cmd_valid = 1'b1; cmd_addr = 32'h3F8; cmd_burst = 3'b001; cmd_len = 8'd4;
    wdata_valid = 1'b1; wdata = 32'hF000_0000;
    step(); cmd_valid = 1'b0; settle();
    chk_bus("t4 c1", 2'b10, 32'h3F8);
    step(); wdata = 32'hF000_0001; settle();
    chk_bus("t4 c2", 2'b11, 32'h3FC);
    step(); wdata = 32'hF000_0002; settle();
    chk_bus("t4 c3 renonseq", 2'b10, 32'h400);
    check("t4 HBURST", 64'(HBURST), 64'd1);
    step(); wdata = 32'hF000_0003; settle();
    chk_bus("t4 c4", 2'b11, 32'h404);
    step(); wdata_valid = 1'b0; settle();
    check("t4 done", 64'(done), 64'd1);
    check("t4 HWDATA", 64'(HWDATA), 64'hF000_0003);
    step(); settle();

    // T5 INCR8 at 0x500, ERROR on beat 3 (zero-based)
    hs_base = hs_cnt;
    cmd_valid = 1'b1; cmd_addr = 32'h500; cmd_burst = 3'b101;
    wdata_valid = 1'b1; wdata = 32'hB000_0000;
    step(); cmd_valid = 1'b0; settle();
    chk_bus("t5 c1", 2'b10, 32'h500);
    step(); wdata = 32'hB000_0001; settle();
    step(); wdata = 32'hB000_0002; settle();
    step(); wdata = 32'hB000_0003; settle();
    chk_bus("t5 c4", 2'b11, 32'h50C);
    step(); wdata = 32'hB000_0004; HREADY = 1'b0; HRESP = 1'b1; settle();
    check("t5 err1 HTRANS", 64'(HTRANS), 64'd0);
    check("t5 err1 wdata_ready", 64'(wdata_ready), 64'd0);
    check("t5 err1 done", 64'(done), 64'd0);
    check("t5 err1 HWDATA", 64'(HWDATA), 64'hB000_0003);
    step(); HREADY = 1'b1; settle();
    check("t5 err2 done", 64'(done), 64'd1);
    check("t5 err2 err", 64'(err), 64'd1);
    check("t5 err2 HTRANS", 64'(HTRANS), 64'd0);
    check("t5 err2 wdata_ready", 64'(wdata_ready), 64'd0);
    step(); HRESP = 1'b0; settle();
    check("t5 beats consumed", 64'(hs_cnt - hs_base), 64'd4);
    check("t5 cmd_ready", 64'(cmd_ready), 64'd1);
    check("t5 done off", 64'(done), 64'd0);

    // T6 reset mid INCR16 after beat 5, then a fresh SINGLE
    cmd_valid = 1'b1; cmd_addr = 32'h600; cmd_burst = 3'b111;
    wdata_valid = 1'b1; wdata = 32'hC000_0000;
    step(); cmd_valid = 1'b0; settle();
    step(); settle();
    step(); settle();
    step(); settle();
    step(); settle();
    chk_bus("t6 beat5", 2'b11, 32'h610);
    step(); HRESET = 1'b1; settle();
    step(); HRESET = 1'b0; settle();
    check("t6 HTRANS", 64'(HTRANS), 64'd0);
    check("t6 cmd_ready", 64'(cmd_ready), 64'd1);
    check("t6 done", 64'(done), 64'd0);
    check("t6 HADDR", 64'(HADDR), 64'd0);
    check("t6 HBURST", 64'(HBURST), 64'd0);
    check("t6 HWDATA", 64'(HWDATA), 64'd0);
    cmd_valid = 1'b1; cmd_addr = 32'h700; cmd_burst = 3'b000; wdata = 32'hCAFE_F00D;
    step(); cmd_valid = 1'b0; settle();
    chk_bus("t6 single", 2'b10, 32'h700);
    step(); wdata_valid = 1'b0; settle();
    check("t6 single HWDATA", 64'(HWDATA), 64'hCAFE_F00D);
    check("t6 single done", 64'(done), 64'd1);
    check("t6 single err", 64'(err), 64'd0);
    step(); settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
